// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, complex sample type and the UART receiver state encoding.
// The receiver gains a PARITY state when FFT_UART_PARITY_EN is defined.
package fft_pkg;
    localparam int SAMPLE_W        = 9;
    localparam int N_POINTS        = 8;
    localparam int BYTES_PER_FRAME = 2 * N_POINTS;
    localparam int FRAME_W         = 2 * SAMPLE_W * N_POINTS;

    // re occupies the upper half so sample k lands at [18k+17:18k+9] in a packed frame
    typedef struct packed {
        logic [SAMPLE_W-1:0] re;
        logic [SAMPLE_W-1:0] im;
    } complex_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef FFT_UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    function automatic logic [SAMPLE_W-1:0] sext8(input logic [7:0] b);
        return {{(SAMPLE_W-8){b[7]}}, b};
    endfunction
endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser and mid-bit sampling FSM, 8N1 or 8E1 when FFT_UART_PARITY_EN is defined.
// byte_stb / err_stb are single-cycle strobes coincident with the stop-bit mid-sample.
module uart_rx_core
    import fft_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] rx_byte,
    output logic       byte_stb,
    output logic       err_stb
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);

    logic             rxd_meta, rxd_sync;
    rx_state_t        state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bit_idx, bit_d;
    logic [7:0]       shreg, sh_d;
    logic             perr, perr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            state    <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            perr     <= 1'b0;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
            state    <= state_d;
            cnt      <= cnt_d;
            bit_idx  <= bit_d;
            shreg    <= sh_d;
            perr     <= perr_d;
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt + 1'b1;
        bit_d    = bit_idx;
        sh_d     = shreg;
        perr_d   = perr;
        byte_stb = 1'b0;
        err_stb  = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rxd_sync) state_d = RX_START;
            end
            RX_START: begin
                if (cnt == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    perr_d  = 1'b0;
                    state_d = rxd_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == FULL) begin
                    cnt_d = '0;
                    sh_d  = {rxd_sync, shreg[7:1]};
                    bit_d = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef FFT_UART_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end
                end
            end
`ifdef FFT_UART_PARITY_EN
            RX_PARITY: begin
                if (cnt == FULL) begin
                    cnt_d   = '0;
                    perr_d  = ^{shreg, rxd_sync};
                    state_d = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (cnt == FULL) begin
                    cnt_d = '0;
                    if (rxd_sync && !perr) begin
                        byte_stb = 1'b1;
                        state_d  = RX_IDLE;
                    end else begin
                        err_stb = 1'b1;
                        // a low stop bit may be a break; hold off until the line idles
                        state_d = rxd_sync ? RX_IDLE : RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                cnt_d = '0;
                if (rxd_sync) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign rx_byte = shreg;
endmodule

// File: rtl/fft_sample_loader.sv
// UART-fed frame assembler for the 8-point FFT: 16 signed bytes -> one 144-bit frame on valid/ready.
// Define FFT_UART_PARITY_EN to receive 8E1 instead of 8N1.
module fft_sample_loader
    import fft_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               uart_rxd,
    output logic [FRAME_W-1:0] frame_data,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic               rx_err,
    output logic               overflow
);
    localparam int IDX_W = $clog2(BYTES_PER_FRAME);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_FRAME - 1);

    logic [7:0]                  rx_byte;
    logic                        byte_stb, err_stb;
    logic [IDX_W-1:0]            idx;
    logic [IDX_W-2:0]            slot;
    complex_t [N_POINTS-1:0]     asm_q, asm_d, frame_q;
    logic                        frame_done, accept;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .uart_rxd (uart_rxd),
        .rx_byte  (rx_byte),
        .byte_stb (byte_stb),
        .err_stb  (err_stb)
    );

    assign slot       = idx[IDX_W-1:1];
    assign frame_done = byte_stb && (idx == LAST_IDX);
    assign accept     = frame_valid && frame_ready;

    // asm_d carries the incoming byte so the last byte transfers on its own strobe edge
    always_comb begin
        asm_d = asm_q;
        if (byte_stb) begin
            if (idx[0]) asm_d[slot].im = sext8(rx_byte);
            else        asm_d[slot].re = sext8(rx_byte);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_q       <= '0;
            idx         <= '0;
            frame_q     <= '0;
            frame_valid <= 1'b0;
            rx_err      <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            rx_err   <= err_stb;
            overflow <= frame_done && frame_valid && !frame_ready;
            if (byte_stb) begin
                asm_q <= asm_d;
                idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            if (frame_done && (!frame_valid || frame_ready)) begin
                frame_q     <= asm_d;
                frame_valid <= 1'b1;
            end else if (accept) begin
                frame_valid <= 1'b0;
            end
        end
    end

    assign frame_data = frame_q;
endmodule

// File: tb/tb_fft_sample_loader.sv
// Scoreboard bench for fft_sample_loader at CLKS_PER_BIT=4.
module tb_fft_sample_loader;
    localparam int CPB = 4;
`ifdef FFT_UART_PARITY_EN
    localparam int LAT = 3 + CPB / 2 + 10 * CPB;
`else
    localparam int LAT = 3 + CPB / 2 + 9 * CPB;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         uart_rxd = 1'b1;
    logic         frame_ready = 1'b0;
    logic [143:0] frame_data;
    logic         frame_valid, rx_err, overflow;

    fft_sample_loader #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rxd    (uart_rxd),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .rx_err      (rx_err),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0, last_start = 0, rise_cyc = 0;
    int exp_err = 0, exp_ovf = 0, seen_err = 0, seen_ovf = 0;
    logic prev_valid = 1'b0;
    logic [7:0]   m_asm [16];
    int           m_idx = 0;
    logic [143:0] exp_q [$];

    task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [143:0] build_frame();
        logic [143:0] f = '0;
        for (int s = 0; s < 16; s++) begin
            int off = 18 * (s / 2) + ((s % 2 == 0) ? 9 : 0);
            f[off +: 9] = {m_asm[s][7], m_asm[s]};
        end
        return f;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            if (rx_err)   seen_err++;
            if (overflow) seen_ovf++;
            if (frame_valid && !prev_valid) rise_cyc = cyc;
            if (frame_valid && frame_ready) begin
                if (exp_q.size() == 0) check("spurious_frame", 144'(exp_q.size()), 144'd1);
                else                   check("frame", frame_data, exp_q.pop_front());
            end
        end
        prev_valid = frame_valid;
    end

    task automatic bit_period(input logic v);
        uart_rxd = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        uart_rxd = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // model is updated before the line is driven so the frame is queued before the DUT shows it
    task automatic send_byte(input logic [7:0] b, input logic stop);
        if (stop) begin
            m_asm[m_idx] = b;
            m_idx++;
            if (m_idx == 16) begin
                m_idx = 0;
                if (exp_q.size() == 0 || frame_ready) exp_q.push_back(build_frame());
                else exp_ovf++;
            end
        end else begin
            exp_err++;
        end
        last_start = cyc;
        bit_period(1'b0);
        for (int i = 0; i < 8; i++) bit_period(b[i]);
`ifdef FFT_UART_PARITY_EN
        bit_period(^b);
`endif
        bit_period(stop);
        bit_period(1'b1);
        bit_period(1'b1);
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    endtask

    task automatic checkpoint(input string tag);
        idle(4 * CPB);
        check({tag, "_drain"}, 144'(exp_q.size()), 144'd0);
        check({tag, "_err"}, 144'(seen_err), 144'(exp_err));
        check({tag, "_ovf"}, 144'(seen_ovf), 144'(exp_ovf));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 144'(frame_valid), 144'd0);
        check("rst_data", frame_data, 144'd0);
        check("rst_err", 144'(rx_err), 144'd0);
        check("rst_ovf", 144'(overflow), 144'd0);
        rst = 1'b1;
        idle(3);

        // ramp frame, consumer always ready
        frame_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send_byte(8'(k + 1), 1'b1);
            send_byte(8'h00, 1'b1);
        end
        checkpoint("t1");
        check("t1_latency", 144'(rise_cyc - last_start), 144'(LAT));
        check("t1_sample0", 144'(frame_data[17:0]), 144'h00200);
        check("t1_valid_low", 144'(frame_valid), 144'd0);

        // sign extension extremes
        send_byte(8'h80, 1'b1);
        send_byte(8'h7F, 1'b1);
        send_rand(14);
        checkpoint("t2");
        check("t2_sample0", 144'(frame_data[17:0]), 144'({9'h180, 9'h07F}));

        // framing error on 5th byte, then 12 more complete the frame
        send_rand(4);
        send_byte(8'hA5, 1'b0);
        send_rand(12);
        checkpoint("t3");

        // break: line held low well past a character
        uart_rxd = 1'b0;
        repeat (20 * CPB) @(posedge clk);
        #1;
        exp_err++;
        checkpoint("brk");

        // one-clock glitch mid-frame must not disturb idx
        send_rand(6);
        uart_rxd = 1'b0;
        @(posedge clk);
        #1;
        idle(5 * CPB);
        send_rand(10);
        checkpoint("t5");

        // two frames while stalled: second is dropped
        frame_ready = 1'b0;
        send_rand(32);
        idle(4 * CPB);
        check("t4_ovf", 144'(seen_ovf), 144'(exp_ovf));
        check("t4_valid", 144'(frame_valid), 144'd1);
        check("t4_hold", frame_data, (exp_q.size() != 0) ? exp_q[0] : 144'd0);
        frame_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t4_valid_drop", 144'(frame_valid), 144'd0);
        checkpoint("t4");

        // reset during 3rd data bit of byte 9
        send_rand(8);
        bit_period(1'b0);
        bit_period(1'b1);
        bit_period(1'b0);
        uart_rxd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("t6_rst_data", frame_data, 144'd0);
        check("t6_rst_valid", 144'(frame_valid), 144'd0);
        check("t6_rst_err", 144'(rx_err), 144'd0);
        m_idx = 0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(3 * CPB);
        send_rand(16);
        checkpoint("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
